// File: rtl/mu0_control_if.sv
// ============================================================================
//  Module   : mu0_control_if
//  Purpose  : Bundle of controller <-> datapath/memory signals for the MU0
//             control unit. The master modport belongs to the controller; the
//             slave modport belongs to the datapath/memory side.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mu0_control_if #(
  parameter int CNT_W = 16
);
  // Status from the datapath and memory
  logic [3:0]       F;
  logic             N;
  logic             Z;
  logic             Mem_Ack;

  // Control to the datapath and memory
  logic             X_sel;
  logic             Y_sel;
  logic             Addr_sel;
  logic             PC_En;
  logic             IR_En;
  logic             Acc_En;
  logic [1:0]       M;
  logic             Rd;
  logic             Wr;
  logic             Halted;
  logic             Illegal;
  logic [CNT_W-1:0] Instr_Count;

  modport master (
    input  F, N, Z, Mem_Ack,
    output X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Rd, Wr,
           Halted, Illegal, Instr_Count
  );

  modport slave (
    output F, N, Z, Mem_Ack,
    input  X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Rd, Wr,
           Halted, Illegal, Instr_Count
  );
endinterface

`default_nettype wire

// File: rtl/mu0_control.sv
// ============================================================================
//  Module   : mu0_control
//  Purpose  : IDLE/FETCH/EXEC/HALT control unit for the MU0 processor.
//             Decodes the opcode, sequences memory accesses with Mem_Ack
//             handshaking, flags illegal opcodes and counts retired
//             instructions with a saturating counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mu0_control #(
  parameter int CNT_W = 16
) (
  input  logic          Clk,
  input  logic          Reset,    // asynchronous, active-low
  mu0_control_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] c_op_lda = 4'd0;
  localparam logic [3:0] c_op_sto = 4'd1;
  localparam logic [3:0] c_op_add = 4'd2;
  localparam logic [3:0] c_op_sub = 4'd3;
  localparam logic [3:0] c_op_jmp = 4'd4;
  localparam logic [3:0] c_op_jge = 4'd5;
  localparam logic [3:0] c_op_jne = 4'd6;
  localparam logic [3:0] c_op_stp = 4'd7;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  logic             w_mem_op;
  logic             w_stop_op;
  logic             w_exec_done;

  logic             w_x_sel;
  logic             w_y_sel;
  logic             w_addr_sel;
  logic             w_pc_en;
  logic             w_ir_en;
  logic             w_acc_en;
  logic [1:0]       w_m;
  logic             w_rd;
  logic             w_wr;
  logic             w_halted;

  // Opcode class decode and EXEC completion: memory ops wait for Mem_Ack,
  // every other opcode finishes in its single EXEC cycle.
  always_comb begin
    w_mem_op    = (bus.F[3:2] == 2'b00);
    w_stop_op   = (bus.F == c_op_stp) || bus.F[3];
    w_exec_done = (r_state == S_EXEC) && (w_mem_op ? bus.Mem_Ack : 1'b1);
  end

  // Output decode from state and inputs; everything defaults to 0 so IDLE,
  // HALT and unused fields never drive X or a stray enable.
  always_comb begin
    w_x_sel    = 1'b0;
    w_y_sel    = 1'b0;
    w_addr_sel = 1'b0;
    w_pc_en    = 1'b0;
    w_ir_en    = 1'b0;
    w_acc_en   = 1'b0;
    w_m        = 2'b00;
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    w_halted   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_addr_sel = 1'b0;
        w_rd       = 1'b1;
        w_x_sel    = 1'b1;
        w_m        = 2'b10;
        w_ir_en    = bus.Mem_Ack;
        w_pc_en    = bus.Mem_Ack;
      end
      S_EXEC: begin
        case (bus.F)
          c_op_lda: begin
            w_addr_sel = 1'b1;
            w_rd       = 1'b1;
            w_m        = 2'b00;
            w_acc_en   = bus.Mem_Ack;
          end
          c_op_sto: begin
            w_addr_sel = 1'b1;
            w_wr       = 1'b1;
          end
          c_op_add: begin
            w_addr_sel = 1'b1;
            w_rd       = 1'b1;
            w_m        = 2'b01;
            w_acc_en   = bus.Mem_Ack;
          end
          c_op_sub: begin
            w_addr_sel = 1'b1;
            w_rd       = 1'b1;
            w_m        = 2'b11;
            w_acc_en   = bus.Mem_Ack;
          end
          c_op_jmp: begin
            w_y_sel = 1'b1;
            w_pc_en = 1'b1;
          end
          c_op_jge: begin
            w_y_sel = 1'b1;
            w_pc_en = ~bus.N;
          end
          c_op_jne: begin
            w_y_sel = 1'b1;
            w_pc_en = ~bus.Z;
          end
          default: begin
            // STP and illegal opcodes: no request, no enable
          end
        endcase
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        // IDLE: all outputs inactive
      end
    endcase
  end

  // State sequencing, sticky illegal flag and saturating retire counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_FETCH;
        S_FETCH: if (bus.Mem_Ack) r_state <= S_EXEC;
        S_EXEC: begin
          if (w_stop_op) begin
            r_state <= S_HALT;
          end else if (w_exec_done) begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_HALT;
      endcase
      if ((r_state == S_EXEC) && bus.F[3]) begin
        r_illegal <= 1'b1;
      end
      if (w_exec_done && (r_count != '1)) begin
        r_count <= r_count + c_cnt_one;
      end
    end
  end

  assign bus.X_sel       = w_x_sel;
  assign bus.Y_sel       = w_y_sel;
  assign bus.Addr_sel    = w_addr_sel;
  assign bus.PC_En       = w_pc_en;
  assign bus.IR_En       = w_ir_en;
  assign bus.Acc_En      = w_acc_en;
  assign bus.M           = w_m;
  assign bus.Rd          = w_rd;
  assign bus.Wr          = w_wr;
  assign bus.Halted      = w_halted;
  assign bus.Illegal     = r_illegal;
  assign bus.Instr_Count = r_count;

endmodule

`default_nettype wire
